// File: rtl/cpu_pkg.sv
// Shared pipeline constants and types for the fetch stage.
//   PC_W / INST_W   : address and instruction widths
//   NOP_INST        : word loaded into IF/ID for a bubble
//   HALT_INST_DEF   : default halt encoding
//   fetch_state_t   : fetch FSM states
//   align_pc()      : forces a redirect address onto a halfword boundary
package cpu_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned INST_W = 16;

  localparam logic [INST_W-1:0] NOP_INST      = 16'h0000;
  localparam logic [INST_W-1:0] HALT_INST_DEF = 16'hEFFF;

  typedef enum logic [0:0] {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return {a[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory read bus.
//   rdAddr : read address driven by the fetch stage (master)
//   inst   : instruction word returned combinationally by memory (slave)
interface inst_fetch_if;
  import cpu_pkg::*;

  logic [PC_W-1:0]   rdAddr;
  logic [INST_W-1:0] inst;

  modport master (output rdAddr, input inst);
  modport slave  (input rdAddr, output inst);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture d_inst/d_pc2 and mark valid
//   bubble    : load a NOP with valid=0 (wins over load)
//   neither   : hold contents
//   q_*       : registered instruction, PC+step, valid
module ifid_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic [INST_W-1:0] d_inst,
  input  logic [PC_W-1:0]   d_pc2,
  output logic [INST_W-1:0] q_inst,
  output logic [PC_W-1:0]   q_pc2,
  output logic              q_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_inst  <= NOP_INST;
      q_pc2   <= '0;
      q_valid <= 1'b0;
    end else if (bubble) begin
      q_inst  <= NOP_INST;
      q_pc2   <= '0;
      q_valid <= 1'b0;
    end else if (load) begin
      q_inst  <= d_inst;
      q_pc2   <= d_pc2;
      q_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// address, and fills the IF/ID register. Handles branch redirect, flush,
// stall and halting on HALT_INST.
//   clk, rst       : clock, synchronous active-high reset
//   imem           : instruction memory bus (rdAddr out = pc, inst in)
//   stall          : hold pc, IF/ID and state
//   flush          : bubble IF/ID, pc still advances
//   branch_taken   : redirect pc to branch_target (bit0 forced 0)
//   ifid_inst/pc2/valid : IF/ID register contents
//   halted         : fetch FSM is in HALTED
// Optional macro IFETCH_PERF_CNT_EN adds fetch_cnt / bubble_cnt
// saturating 32-bit counters.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC  = 16'h0000,
  parameter logic [INST_W-1:0] HALT_INST = HALT_INST_DEF,
  parameter int unsigned       PC_STEP   = 2
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_if.master        imem,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic [PC_W-1:0]     branch_target,
  output logic [INST_W-1:0]   ifid_inst,
  output logic [PC_W-1:0]     ifid_pc2,
  output logic                ifid_valid,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         bubble_cnt,
`endif
  output logic                halted
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  logic [PC_W-1:0] pc, pc_nxt, pc_inc;
  fetch_state_t    state, state_nxt;
  logic            ifid_ld, ifid_bub;
  logic            unused_bt0;

  assign unused_bt0  = branch_target[0];
  assign pc_inc      = pc + STEP;
  assign imem.rdAddr = pc;
  assign halted      = (state == FS_HALTED);

  // Priority: branch > halted-idle > flush > stall > advance.
  always_comb begin
    pc_nxt    = pc;
    state_nxt = state;
    ifid_ld   = 1'b0;
    ifid_bub  = 1'b0;
    if (branch_taken) begin
      pc_nxt    = align_pc(branch_target);
      state_nxt = FS_RUN;
      ifid_bub  = 1'b1;
    end else if (state == FS_HALTED) begin
      ifid_bub  = 1'b1;
    end else if (flush) begin
      pc_nxt    = pc_inc;
      ifid_bub  = 1'b1;
    end else if (!stall) begin
      ifid_ld   = 1'b1;
      if (imem.inst == HALT_INST) begin
        state_nxt = FS_HALTED;
      end else begin
        pc_nxt    = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= FS_RUN;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  ifid_reg u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_ld),
    .bubble  (ifid_bub),
    .d_inst  (imem.inst),
    .d_pc2   (pc_inc),
    .q_inst  (ifid_inst),
    .q_pc2   (ifid_pc2),
    .q_valid (ifid_valid)
  );

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (ifid_ld && fetch_cnt != '1) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (ifid_bub && state == FS_RUN && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_taken;
  logic [15:0] branch_target;
  logic [15:0] ifid_inst, ifid_pc2;
  logic        ifid_valid, halted;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif
  int nvec = 0;
  int nerr = 0;

  inst_fetch_if bus ();

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0000: return 16'hF120;
      16'h0002: return 16'hF121;
      16'h0004: return 16'h93FF;
      16'h0028: return 16'hC890;
      16'h0036: return 16'hEFFF;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  assign bus.inst = mem_rd(bus.rdAddr);

  inst_fetch #(.RESET_PC(16'h0000), .HALT_INST(16'hEFFF), .PC_STEP(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ifid_inst     (ifid_inst),
    .ifid_pc2      (ifid_pc2),
    .ifid_valid    (ifid_valid),
`ifdef IFETCH_PERF_CNT_EN
    .fetch_cnt     (fetch_cnt),
    .bubble_cnt    (bubble_cnt),
`endif
    .halted        (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    step(); step();
    nvec++; if (bus.rdAddr !== 16'h0000) begin nerr++; $display("FAIL reset_addr got %h exp 0000", bus.rdAddr); end
    nvec++; if (ifid_inst !== 16'h0000) begin nerr++; $display("FAIL reset_inst got %h exp 0000", ifid_inst); end
    nvec++; if (ifid_pc2 !== 16'h0000) begin nerr++; $display("FAIL reset_pc2 got %h exp 0000", ifid_pc2); end
    nvec++; if (ifid_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
    nvec++; if (halted !== 1'b0) begin nerr++; $display("FAIL reset_halted got %b exp 0", halted); end
    rst = 1'b0;
  endtask

  task automatic test_run();
    logic [15:0] exp_i [3];
    exp_i[0] = 16'hF120; exp_i[1] = 16'hF121; exp_i[2] = 16'h93FF;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (bus.rdAddr !== 16'(2*i)) begin nerr++; $display("FAIL run_addr%0d got %h exp %h", i, bus.rdAddr, 16'(2*i)); end
      step();
      nvec++; if (ifid_inst !== exp_i[i]) begin nerr++; $display("FAIL run_inst%0d got %h exp %h", i, ifid_inst, exp_i[i]); end
      nvec++; if (ifid_pc2 !== 16'(2*i+2)) begin nerr++; $display("FAIL run_pc2%0d got %h exp %h", i, ifid_pc2, 16'(2*i+2)); end
      nvec++; if (ifid_valid !== 1'b1) begin nerr++; $display("FAIL run_valid%0d got %b exp 1", i, ifid_valid); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++; if (bus.rdAddr !== 16'h0006) begin nerr++; $display("FAIL stall_addr%0d got %h exp 0006", i, bus.rdAddr); end
      nvec++; if (ifid_inst !== 16'h93FF || ifid_pc2 !== 16'h0006 || ifid_valid !== 1'b1) begin
        nerr++; $display("FAIL stall_ifid%0d got %h/%h/%b exp 93FF/0006/1", i, ifid_inst, ifid_pc2, ifid_valid);
      end
    end
    stall = 1'b0;
    step();
    nvec++; if (ifid_inst !== 16'h5A5C || ifid_pc2 !== 16'h0008) begin
      nerr++; $display("FAIL stall_resume got %h/%h exp 5A5C/0008", ifid_inst, ifid_pc2);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 10; i++) step();
    nvec++; if (bus.rdAddr !== 16'h001C) begin nerr++; $display("FAIL br_pre_addr got %h exp 001C", bus.rdAddr); end
    branch_taken = 1'b1; branch_target = 16'h0029; stall = 1'b1;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    nvec++; if (bus.rdAddr !== 16'h0028) begin nerr++; $display("FAIL br_addr got %h exp 0028", bus.rdAddr); end
    nvec++; if (ifid_valid !== 1'b0 || ifid_inst !== 16'h0000 || ifid_pc2 !== 16'h0000) begin
      nerr++; $display("FAIL br_bubble got %h/%h/%b exp 0000/0000/0", ifid_inst, ifid_pc2, ifid_valid);
    end
    step();
    nvec++; if (ifid_inst !== 16'hC890 || ifid_pc2 !== 16'h002A || ifid_valid !== 1'b1) begin
      nerr++; $display("FAIL br_fetch got %h/%h/%b exp C890/002A/1", ifid_inst, ifid_pc2, ifid_valid);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 6; i++) step();
    nvec++; if (bus.rdAddr !== 16'h0036) begin nerr++; $display("FAIL halt_pre_addr got %h exp 0036", bus.rdAddr); end
    step();
    nvec++; if (ifid_inst !== 16'hEFFF || ifid_valid !== 1'b1 || ifid_pc2 !== 16'h0038) begin
      nerr++; $display("FAIL halt_capture got %h/%h/%b exp EFFF/0038/1", ifid_inst, ifid_pc2, ifid_valid);
    end
    nvec++; if (halted !== 1'b1) begin nerr++; $display("FAIL halt_state got %b exp 1", halted); end
    nvec++; if (bus.rdAddr !== 16'h0036) begin nerr++; $display("FAIL halt_addr got %h exp 0036", bus.rdAddr); end
    stall = 1'b1; flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++; if (halted !== 1'b1 || ifid_valid !== 1'b0 || bus.rdAddr !== 16'h0036) begin
        nerr++; $display("FAIL halt_idle%0d got h=%b v=%b a=%h exp h=1 v=0 a=0036", i, halted, ifid_valid, bus.rdAddr);
      end
    end
    stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b1; branch_target = 16'h0000;
    step();
    branch_taken = 1'b0;
    nvec++; if (halted !== 1'b0 || bus.rdAddr !== 16'h0000 || ifid_valid !== 1'b0) begin
      nerr++; $display("FAIL halt_exit got h=%b a=%h v=%b exp h=0 a=0000 v=0", halted, bus.rdAddr, ifid_valid);
    end
    step();
    nvec++; if (ifid_inst !== 16'hF120 || ifid_valid !== 1'b1) begin
      nerr++; $display("FAIL halt_refetch got %h/%b exp F120/1", ifid_inst, ifid_valid);
    end
  endtask

  task automatic test_wrap_reset();
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    step();
    branch_taken = 1'b0;
    nvec++; if (bus.rdAddr !== 16'hFFFE) begin nerr++; $display("FAIL wrap_addr0 got %h exp FFFE", bus.rdAddr); end
    step();
    nvec++; if (bus.rdAddr !== 16'h0000) begin nerr++; $display("FAIL wrap_addr1 got %h exp 0000", bus.rdAddr); end
    nvec++; if (ifid_inst !== 16'hA5A4 || ifid_pc2 !== 16'h0000) begin
      nerr++; $display("FAIL wrap_ifid got %h/%h exp A5A4/0000", ifid_inst, ifid_pc2);
    end
    step();
    rst = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h1234;
    step();
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    nvec++; if (bus.rdAddr !== 16'h0000 || ifid_inst !== 16'h0000 || ifid_pc2 !== 16'h0000 || ifid_valid !== 1'b0 || halted !== 1'b0) begin
      nerr++; $display("FAIL midreset got a=%h i=%h p=%h v=%b h=%b exp all 0", bus.rdAddr, ifid_inst, ifid_pc2, ifid_valid, halted);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    nvec++; if (ifid_valid !== 1'b0 || bus.rdAddr !== 16'h0002) begin
      nerr++; $display("FAIL flush got v=%b a=%h exp v=0 a=0002", ifid_valid, bus.rdAddr);
    end
    step();
    nvec++; if (ifid_inst !== 16'hF121 || ifid_valid !== 1'b1) begin
      nerr++; $display("FAIL flush_next got %h/%b exp F121/1", ifid_inst, ifid_valid);
    end
  endtask

`ifdef IFETCH_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    nvec++; if (fetch_cnt !== 32'd5) begin nerr++; $display("FAIL perf_fetch got %0d exp 5", fetch_cnt); end
    nvec++; if (bubble_cnt !== 32'd1) begin nerr++; $display("FAIL perf_bubble got %0d exp 1", bubble_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_branch();
    test_halt();
    test_wrap_reset();
    test_flush();
`ifdef IFETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
